// File: rtl/tea_pkg.sv
// Shared constants, FSM state encoding and elaboration helpers for the
// TEA/XTEA block engine.
package tea_pkg;

    localparam logic [31:0] DELTA_DEFAULT = 32'h9e3779b9;

    localparam int unsigned MODE_DECRYPT_BIT = 0;
    localparam int unsigned MODE_XTEA_BIT    = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Starting sum for decryption; the caller truncates to WORD_SIZE.
    function automatic logic [63:0] delta_times_rounds(input logic [31:0] delta,
                                                       input int unsigned rounds);
        return {32'd0, delta} * {32'd0, rounds};
    endfunction

endpackage

// File: rtl/tea_xtea_engine_if.sv
// Block-in / block-out handshake bundle for tea_xtea_engine.
interface tea_xtea_engine_if #(
    parameter int WORD_SIZE = 32
);
    logic                 iValid;
    logic                 oReady;
    logic                 iDecrypt;
    logic                 iXtea;
    logic [WORD_SIZE-1:0] iV0;
    logic [WORD_SIZE-1:0] iV1;
    logic [WORD_SIZE-1:0] iK0;
    logic [WORD_SIZE-1:0] iK1;
    logic [WORD_SIZE-1:0] iK2;
    logic [WORD_SIZE-1:0] iK3;
    logic                 oValid;
    logic                 iReady;
    logic [WORD_SIZE-1:0] oC0;
    logic [WORD_SIZE-1:0] oC1;
    logic                 oDone;

    modport master (
        output iValid, iDecrypt, iXtea, iV0, iV1, iK0, iK1, iK2, iK3, iReady,
        input  oReady, oValid, oC0, oC1, oDone
    );

    modport slave (
        input  iValid, iDecrypt, iXtea, iV0, iV1, iK0, iK1, iK2, iK3, iReady,
        output oReady, oValid, oC0, oC1, oDone
    );
endinterface

// File: rtl/tea_round.sv
// One full TEA or XTEA round (both halves) in either direction; purely
// combinational.
module tea_round #(
    parameter int                   WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] DELTA_W   = WORD_SIZE'(32'h9e3779b9)
) (
    input  logic [WORD_SIZE-1:0] v0,
    input  logic [WORD_SIZE-1:0] v1,
    input  logic [WORD_SIZE-1:0] sum,
    input  logic [WORD_SIZE-1:0] k0,
    input  logic [WORD_SIZE-1:0] k1,
    input  logic [WORD_SIZE-1:0] k2,
    input  logic [WORD_SIZE-1:0] k3,
    input  logic                 decrypt,
    input  logic                 xtea,
    output logic [WORD_SIZE-1:0] v0_next,
    output logic [WORD_SIZE-1:0] v1_next,
    output logic [WORD_SIZE-1:0] sum_next
);

    function automatic logic [WORD_SIZE-1:0] tea_f(input logic [WORD_SIZE-1:0] v,
                                                   input logic [WORD_SIZE-1:0] ka,
                                                   input logic [WORD_SIZE-1:0] kb,
                                                   input logic [WORD_SIZE-1:0] s);
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

    function automatic logic [WORD_SIZE-1:0] xtea_mix(input logic [WORD_SIZE-1:0] v);
        return ((v << 4) ^ (v >> 5)) + v;
    endfunction

    logic [WORD_SIZE-1:0] sum_inc;
    logic [WORD_SIZE-1:0] sum_dec;
    logic [WORD_SIZE-1:0] half_t;

    function automatic logic [WORD_SIZE-1:0] key_sel(input logic [1:0] idx,
                                                     input logic [WORD_SIZE-1:0] a,
                                                     input logic [WORD_SIZE-1:0] b,
                                                     input logic [WORD_SIZE-1:0] c,
                                                     input logic [WORD_SIZE-1:0] d);
        case (idx)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return d;
        endcase
    endfunction

    always_comb begin
        sum_inc  = sum + DELTA_W;
        sum_dec  = sum - DELTA_W;
        half_t   = '0;
        v0_next  = v0;
        v1_next  = v1;
        sum_next = sum;
        // Second half always consumes the freshly updated first half.
        case ({xtea, decrypt})
            2'b00: begin
                half_t   = v0 + tea_f(v1, k0, k1, sum_inc);
                v0_next  = half_t;
                v1_next  = v1 + tea_f(half_t, k2, k3, sum_inc);
                sum_next = sum_inc;
            end
            2'b01: begin
                half_t   = v1 - tea_f(v0, k2, k3, sum);
                v1_next  = half_t;
                v0_next  = v0 - tea_f(half_t, k0, k1, sum);
                sum_next = sum_dec;
            end
            2'b10: begin
                half_t   = v0 + (xtea_mix(v1) ^ (sum + key_sel(sum[1:0], k0, k1, k2, k3)));
                v0_next  = half_t;
                v1_next  = v1 + (xtea_mix(half_t) ^
                                 (sum_inc + key_sel(sum_inc[12:11], k0, k1, k2, k3)));
                sum_next = sum_inc;
            end
            default: begin
                half_t   = v1 - (xtea_mix(v0) ^ (sum + key_sel(sum[12:11], k0, k1, k2, k3)));
                v1_next  = half_t;
                v0_next  = v0 - (xtea_mix(half_t) ^
                                 (sum_dec + key_sel(sum_dec[1:0], k0, k1, k2, k3)));
                sum_next = sum_dec;
            end
        endcase
    end

endmodule

// File: rtl/tea_xtea_engine.sv
// Iterative TEA/XTEA 64-bit block engine: one round per clock, per-block
// mode select, valid/ready on both sides.
module tea_xtea_engine
    import tea_pkg::*;
#(
    parameter int          WORD_SIZE    = 32,
    parameter logic [31:0] DELTA        = DELTA_DEFAULT,
    parameter int unsigned ROUND_NUMBER = 32
) (
    input  logic              clk,
    input  logic              rst,
    tea_xtea_engine_if.slave  bus
);

    localparam logic [WORD_SIZE-1:0] DELTA_W  = WORD_SIZE'(DELTA);
    localparam logic [WORD_SIZE-1:0] SUM_DEC  =
        WORD_SIZE'(delta_times_rounds(DELTA, ROUND_NUMBER));
    localparam logic [7:0]           LAST_CNT = 8'(ROUND_NUMBER - 1);

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
    logic [WORD_SIZE-1:0] k0_q, k0_d, k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
    logic [1:0]           mode_q, mode_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;

    logic                 ready;
    logic                 accept;
    logic [WORD_SIZE-1:0] rv0, rv1, rsum;

    tea_round #(
        .WORD_SIZE (WORD_SIZE),
        .DELTA_W   (DELTA_W)
    ) u_round (
        .v0       (v0_q),
        .v1       (v1_q),
        .sum      (sum_q),
        .k0       (k0_q),
        .k1       (k1_q),
        .k2       (k2_q),
        .k3       (k3_q),
        .decrypt  (mode_q[MODE_DECRYPT_BIT]),
        .xtea     (mode_q[MODE_XTEA_BIT]),
        .v0_next  (rv0),
        .v1_next  (rv1),
        .sum_next (rsum)
    );

    assign ready  = (state_q == IDLE) | ((state_q == DONE) & bus.iReady);
    assign accept = bus.iValid & ready;

    always_comb begin
        state_d = state_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        sum_d   = sum_q;
        k0_d    = k0_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        k3_d    = k3_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        case (state_q)
            RUN: begin
                v0_d  = rv0;
                v1_d  = rv1;
                sum_d = rsum;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                if (bus.iReady) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        // A load overrides the DONE->IDLE default so back-to-back costs no bubble.
        if (accept) begin
            state_d                  = RUN;
            valid_d                  = 1'b0;
            v0_d                     = bus.iV0;
            v1_d                     = bus.iV1;
            k0_d                     = bus.iK0;
            k1_d                     = bus.iK1;
            k2_d                     = bus.iK2;
            k3_d                     = bus.iK3;
            mode_d[MODE_DECRYPT_BIT] = bus.iDecrypt;
            mode_d[MODE_XTEA_BIT]    = bus.iXtea;
            cnt_d                    = '0;
            sum_d                    = bus.iDecrypt ? SUM_DEC : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            v0_q    <= '0;
            v1_q    <= '0;
            sum_q   <= '0;
            k0_q    <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            k3_q    <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            sum_q   <= sum_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            k3_q    <= k3_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign bus.oReady = ready;
    assign bus.oValid = valid_q;
    assign bus.oDone  = done_q;
    assign bus.oC0    = v0_q;
    assign bus.oC1    = v1_q;

endmodule

// File: tb/tb_tea_xtea_engine.sv
// Self-checking bench for tea_xtea_engine: three builds (32, 1 and 64 rounds)
// checked against a plain-arithmetic TEA/XTEA reference.
module tb_tea_xtea_engine;

    localparam logic [31:0] DELTA = 32'h9e3779b9;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [2:0]        iv, dc, xt, rd;
    logic [2:0][31:0]  a_i, b_i;
    logic [2:0][127:0] k_i;
    logic [2:0]        ov, ordy, od;
    logic [2:0][31:0]  c0, c1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tea_xtea_engine_if #(.WORD_SIZE(32)) bus ();

        assign bus.iValid   = iv[g];
        assign bus.iDecrypt = dc[g];
        assign bus.iXtea    = xt[g];
        assign bus.iReady   = rd[g];
        assign bus.iV0      = a_i[g];
        assign bus.iV1      = b_i[g];
        assign bus.iK0      = k_i[g][127:96];
        assign bus.iK1      = k_i[g][95:64];
        assign bus.iK2      = k_i[g][63:32];
        assign bus.iK3      = k_i[g][31:0];
        assign ov[g]        = bus.oValid;
        assign ordy[g]      = bus.oReady;
        assign od[g]        = bus.oDone;
        assign c0[g]        = bus.oC0;
        assign c1[g]        = bus.oC1;

        tea_xtea_engine #(
            .WORD_SIZE    (32),
            .DELTA        (DELTA),
            .ROUND_NUMBER (g == 0 ? 32 : (g == 1 ? 1 : 64))
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] ref_block(input logic [31:0] a, input logic [31:0] b,
                                              input logic [127:0] key, input bit dec,
                                              input bit x, input int n);
        logic [31:0] k[4];
        logic [31:0] v0, v1, sum;
        k[0] = key[127:96];
        k[1] = key[95:64];
        k[2] = key[63:32];
        k[3] = key[31:0];
        v0 = a;
        v1 = b;
        sum = dec ? DELTA * 32'(n) : 32'd0;
        for (int i = 0; i < n; i++) begin
            if (!x && !dec) begin
                sum += DELTA;
                v0 += ((v1 << 4) + k[0]) ^ (v1 + sum) ^ ((v1 >> 5) + k[1]);
                v1 += ((v0 << 4) + k[2]) ^ (v0 + sum) ^ ((v0 >> 5) + k[3]);
            end else if (!x) begin
                v1 -= ((v0 << 4) + k[2]) ^ (v0 + sum) ^ ((v0 >> 5) + k[3]);
                v0 -= ((v1 << 4) + k[0]) ^ (v1 + sum) ^ ((v1 >> 5) + k[1]);
                sum -= DELTA;
            end else if (!dec) begin
                v0 += (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]);
                sum += DELTA;
                v1 += (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]);
            end else begin
                v1 -= (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]);
                sum -= DELTA;
                v0 -= (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]);
            end
        end
        return {v0, v1};
    endfunction

    // Drives one block into build d, scrambles inputs after the accept edge,
    // and returns the result, latency in edges and oDone at/after the rise.
    task automatic run_block(input int d, input logic [31:0] a, input logic [31:0] b,
                             input logic [127:0] key, input bit dec, input bit x,
                             output logic [31:0] r0, output logic [31:0] r1,
                             output int lat, output bit done_rise, output bit done_after);
        int n;
        a_i[d] = a;
        b_i[d] = b;
        k_i[d] = key;
        dc[d]  = dec;
        xt[d]  = x;
        rd[d]  = 1'b1;
        iv[d]  = 1'b1;
        n = 0;
        while (!ordy[d] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        iv[d]  = 1'b0;
        a_i[d] = $urandom;
        b_i[d] = $urandom;
        k_i[d] = {$urandom, $urandom, $urandom, $urandom};
        dc[d]  = ~dec;
        xt[d]  = ~x;
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (ov[d]) begin
                lat = i;
                break;
            end
        end
        r0 = c0[d];
        r1 = c1[d];
        done_rise = od[d];
        @(posedge clk); #1;
        done_after = od[d];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (ov[d] !== 1'b0 || od[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_flags dut=%0d got valid=%b done=%b exp 0/0", d, ov[d], od[d]);
            end
            total++;
            if (c0[d] !== 32'd0 || c1[d] !== 32'd0) begin
                bad++;
                $display("FAIL reset_data dut=%0d got %h %h exp 0 0", d, c0[d], c1[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (ordy[d] !== 1'b1) begin
                bad++;
                $display("FAIL reset_ready dut=%0d got %b exp 1", d, ordy[d]);
            end
        end
    endtask

    task automatic test_vector(input bit x, input logic [31:0] e0, input logic [31:0] e1);
        logic [31:0] r0, r1;
        int lat;
        bit dr, da;
        run_block(0, 32'd0, 32'd0, 128'd0, 1'b0, x, r0, r1, lat, dr, da);
        total++;
        if (r0 !== e0 || r1 !== e1) begin
            bad++;
            $display("FAIL vector_x%0d got %h %h exp %h %h", x, r0, r1, e0, e1);
        end
        total++;
        if (lat != 32) begin
            bad++;
            $display("FAIL vector_latency got %0d exp 32", lat);
        end
        total++;
        if (dr !== 1'b1 || da !== 1'b0) begin
            bad++;
            $display("FAIL vector_done_pulse got rise=%b after=%b exp 1/0", dr, da);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] key;
        logic [31:0] a, b, r0, r1, p0, p1;
        logic [63:0] exp;
        bit x, dec, dr, da;
        int lat;
        for (int it = 0; it < 8; it++) begin
            if (it < 2) begin
                key = {32'h132acf42, 32'h234acb45, 32'h3235acbe, 32'h4533f235};
                a = 32'h3d45f7a7;
                b = 32'h235fcb21;
                x = (it == 1);
                dec = 1'b0;
            end else begin
                key = {$urandom, $urandom, $urandom, $urandom};
                a = $urandom;
                b = $urandom;
                x = 1'($urandom);
                dec = 1'($urandom);
            end
            exp = ref_block(a, b, key, dec, x, 32);
            run_block(0, a, b, key, dec, x, r0, r1, lat, dr, da);
            total++;
            if ({r0, r1} !== exp) begin
                bad++;
                $display("FAIL rt_forward it=%0d got %h%h exp %h", it, r0, r1, exp);
            end
            run_block(0, r0, r1, key, ~dec, x, p0, p1, lat, dr, da);
            total++;
            if (p0 !== a || p1 !== b) begin
                bad++;
                $display("FAIL rt_inverse it=%0d got %h %h exp %h %h", it, p0, p1, a, b);
            end
            total++;
            if (lat != 32) begin
                bad++;
                $display("FAIL rt_latency it=%0d got %0d exp 32", it, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k1, k2;
        logic [31:0] a1, b1, a2, b2;
        logic [63:0] e1, e2;
        int lat;
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        e1 = ref_block(a1, b1, k1, 1'b0, 1'b0, 32);
        e2 = ref_block(a2, b2, k2, 1'b1, 1'b1, 32);
        rd[0] = 1'b0;
        a_i[0] = a1; b_i[0] = b1; k_i[0] = k1; dc[0] = 1'b0; xt[0] = 1'b0;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        a_i[0] = a2; b_i[0] = b2; k_i[0] = k2; dc[0] = 1'b1; xt[0] = 1'b1;
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (ov[0]) begin
                lat = i;
                break;
            end
        end
        total++;
        if (lat != 32) begin
            bad++;
            $display("FAIL bp_latency got %0d exp 32", lat);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (ov[0] !== 1'b1 || ordy[0] !== 1'b0 || od[0] !== (i == 0)) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got valid=%b ready=%b done=%b", i, ov[0], ordy[0], od[0]);
            end
            total++;
            if ({c0[0], c1[0]} !== e1) begin
                bad++;
                $display("FAIL bp_data cyc=%0d got %h%h exp %h", i, c0[0], c1[0], e1);
            end
            @(posedge clk); #1;
        end
        rd[0] = 1'b1;
        #1;
        total++;
        if (ordy[0] !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready got %b exp 1", ordy[0]);
        end
        @(posedge clk); #1;
        iv[0] = 1'b0;
        total++;
        if (ov[0] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_valid_drop got %b exp 0", ov[0]);
        end
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (ov[0]) begin
                lat = i;
                break;
            end
        end
        total++;
        if (lat != 32 || {c0[0], c1[0]} !== e2) begin
            bad++;
            $display("FAIL b2b_result got lat=%0d %h%h exp lat=32 %h", lat, c0[0], c1[0], e2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] key;
        logic [31:0] a, b, r0, r1;
        int lat;
        bit dr, da, seen;
        key = {$urandom, $urandom, $urandom, $urandom};
        a_i[0] = $urandom; b_i[0] = $urandom; k_i[0] = key; dc[0] = 1'b0; xt[0] = 1'b1;
        rd[0] = 1'b1;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        total++;
        if (ov[0] !== 1'b0 || od[0] !== 1'b0 || c0[0] !== 32'd0) begin
            bad++;
            $display("FAIL midrst_state got valid=%b done=%b c0=%h exp 0/0/0", ov[0], od[0], c0[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ov[0] || od[0]) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL midrst_no_output got %b exp 0", seen);
        end
        a = $urandom;
        b = $urandom;
        run_block(0, a, b, key, 1'b0, 1'b0, r0, r1, lat, dr, da);
        total++;
        if ({r0, r1} !== ref_block(a, b, key, 1'b0, 1'b0, 32) || lat != 32) begin
            bad++;
            $display("FAIL midrst_recover got lat=%0d %h%h exp lat=32 %h", lat, r0, r1,
                     ref_block(a, b, key, 1'b0, 1'b0, 32));
        end
    endtask

    task automatic test_rounds(input int d, input int n, input int iters);
        logic [127:0] key;
        logic [31:0] a, b, r0, r1, p0, p1;
        logic [63:0] exp;
        int lat;
        bit x, dr, da;
        for (int it = 0; it < iters; it++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            a = $urandom;
            b = $urandom;
            x = 1'(it);
            exp = ref_block(a, b, key, 1'b0, x, n);
            run_block(d, a, b, key, 1'b0, x, r0, r1, lat, dr, da);
            total++;
            if ({r0, r1} !== exp || lat != n) begin
                bad++;
                $display("FAIL rn%0d_enc it=%0d got lat=%0d %h%h exp lat=%0d %h", n, it, lat, r0, r1, n, exp);
            end
            total++;
            if (dr !== 1'b1 || da !== 1'b0) begin
                bad++;
                $display("FAIL rn%0d_done it=%0d got rise=%b after=%b exp 1/0", n, it, dr, da);
            end
            run_block(d, r0, r1, key, 1'b1, x, p0, p1, lat, dr, da);
            total++;
            if (p0 !== a || p1 !== b || lat != n) begin
                bad++;
                $display("FAIL rn%0d_dec it=%0d got lat=%0d %h %h exp lat=%0d %h %h", n, it, lat, p0, p1, n, a, b);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        iv  = '0;
        dc  = '0;
        xt  = '0;
        rd  = '1;
        a_i = '0;
        b_i = '0;
        k_i = '0;
        test_reset();
        test_vector(1'b0, 32'h41ea3a0a, 32'h94baa940);
        test_vector(1'b1, 32'hdee9d4d8, 32'hf7131ed9);
        test_round_trip();
        test_back_to_back();
        test_reset_mid_run();
        test_rounds(1, 1, 4);
        test_rounds(2, 64, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tea_xtea_engine.md
Name: tea_xtea_engine

Overview:
- Parametrised successor to the fixed 32-round TEA `cipher` block.
- Iterative 64-bit block engine: one full round per clock (both halves).
- Per-block selection of encrypt/decrypt and TEA/XTEA.
- Valid/ready handshakes on input and output; latches key and mode per block. Sits between the key/data source and the output buffer.

Parameters:
- WORD_SIZE, 32, half-block width; shifts are fixed at 4/5. Only 32 is standards-conformant.
- DELTA, 32'h9e3779b9, key-schedule constant, truncated to WORD_SIZE.
- ROUND_NUMBER, 32, cycles/rounds per block, 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- iValid  in  1  input block valid.
- oReady  out  1  engine can accept a block.
- iDecrypt  in  1  1 = decrypt, 0 = encrypt; sampled at accept.
- iXtea  in  1  1 = XTEA, 0 = TEA; sampled at accept.
- iV0, iV1  in  WORD_SIZE each  input half-blocks.
- iK0..iK3  in  WORD_SIZE each  key words; sampled at accept.
- oValid  out  1  result valid; held until taken.
- iReady  in  1  downstream accepts result.
- oC0, oC1  out  WORD_SIZE each  result half-blocks.
- oDone  out  1  one-cycle pulse when oValid rises (legacy-compatible).

Behaviour:
- Reset (async, any state): state=IDLE; oValid=0, oDone=0, oC0=oC1=0; round counter=0; sum=0. oReady is 1 once reset is released.
- FSM states: IDLE, RUN, DONE.
- oReady = (IDLE) | (DONE & iReady).
- Accept = iValid & oReady. On the accept edge:
  - latch V, K, mode, and round counter=0.
  - sum = 0 for encrypt; DELTA*ROUND_NUMBER mod 2^WORD_SIZE for decrypt, as an elaborated constant.
  - go to RUN.
- RUN: one round per edge; counter increments.
  - After the round with counter==ROUND_NUMBER-1: go to DONE, oValid=1, oDone=1 for one cycle.
  - Latency: accept at edge k gives oValid high after edge k+ROUND_NUMBER.
- DONE: oC0/oC1 stable and oValid held while iReady=0.
  - iReady=1 and iValid=0: go to IDLE, oValid=0.
  - iReady=1 and iValid=1: back-to-back accept; load the new block, go to RUN, oValid=0. Sustained throughput is 1 block per ROUND_NUMBER+1 cycles.
- Input changes while not accepted are ignored. iValid may be asserted without waiting for oReady.
- TEA encrypt round:
  - sum+=DELTA.
  - v0+=((v1<<4)+k0)^(v1+sum)^((v1>>5)+k1).
  - v1+=((v0<<4)+k2)^(v0+sum)^((v0>>5)+k3), using the new v0 and sum.
- TEA decrypt round is the exact inverse:
  - v1-= f(v0, k2, k3).
  - v0-= f(v1, k0, k1).
  - then sum-=DELTA.
- XTEA encrypt round:
  - v0+=(((v1<<4)^(v1>>5))+v1)^(sum+k[sum[1:0]]).
  - sum+=DELTA.
  - v1+=(((v0<<4)^(v0>>5))+v0)^(sum+k[sum[12:11]]).
- XTEA decrypt round: exact inverse ordering.
- Arithmetic: all operations modulo 2^WORD_SIZE; >> is logical.
- Reset mid-RUN aborts the block; no oValid or oDone follows.

Decomposition:
- Package tea_pkg:
  - DELTA default.
  - state encoding (IDLE/RUN/DONE).
  - mode bit positions.
  - function computing DELTA*ROUND_NUMBER.
- Sub-module tea_round: purely combinational single round. Inputs: v0, v1, sum, k0..k3, decrypt, xtea. Outputs: next v0, next v1, next sum. The engine holds the FSM, counter and registers only.

Test Plan:
- TEA encrypt: key 0, v0=v1=0, ROUND_NUMBER 32 -> oC0=41ea3a0a, oC1=94baa940. oValid and oDone at accept+32 cycles; oDone lasts 1 cycle.
- XTEA encrypt: key 0, v0=v1=0 -> oC0=dee9d4d8, oC1=f7131ed9.
- Round trip: key 132acf42/234acb45/3235acbe/4533f235, V=3d45f7a7/235fcb21. Encrypt, then decrypt the result in both modes -> original V returned.
- Backpressure: hold iReady=0 for 10 cycles after oValid -> oC stable, oValid held, oReady=0, second iValid not accepted. Releasing iReady with iValid=1 -> back-to-back accept in the same cycle.
- Reset mid-RUN at round 10 -> oValid=0, oDone never pulses. A new block after reset produces the correct result.
- ROUND_NUMBER=1 and =64 builds -> latency 1 and 64 cycles. Decrypt of encrypt output returns the plaintext.
